// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage load/store initiator. Takes one request at a time from the
// pipeline, checks alignment and funct3 legality, then either issues a
// one-cycle write strobe or a one-cycle read strobe. For a read, it waits a
// fixed number of cycles for the synchronous memory data. Load data is
// extracted and sign/zero-extended before it is returned on a response
// channel. The response is held until it is accepted.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req_*           request channel (valid/ready); we=1 store, we=0 load
//   resp_*          response channel; rdata is 0 for stores and errors
//   MemWrite_en     write strobe to data memory (registered)
//   MemRead_en      read strobe to data memory (registered)
//   MEM_funct3_o    access size/type to data memory (registered)
//   mem_addr_o      byte address to memory (registered)
//   mem_wdata_o     store data to memory (registered)
//   mem_rdata_i     read data from memory, RD_LATENCY edges after the read
//                   strobe is sampled
//
// RD_LATENCY must be in 1..4.
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  MemWrite_en,
  output logic                  MemRead_en,
  output logic [2:0]            MEM_funct3_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam logic [2:0] FUNCT3_LB  = 3'd0;
  localparam logic [2:0] FUNCT3_LH  = 3'd1;
  localparam logic [2:0] FUNCT3_LW  = 3'd2;
  localparam logic [2:0] FUNCT3_LBU = 3'd4;
  localparam logic [2:0] FUNCT3_LHU = 3'd5;
  localparam logic [2:0] FUNCT3_SB  = 3'd0;
  localparam logic [2:0] FUNCT3_SH  = 3'd1;
  localparam logic [2:0] FUNCT3_SW  = 3'd2;

  // The WAIT counter is loaded with RD_LATENCY-1, which is at most 3.
  localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t                state_q,      state_d;
  logic [1:0]            cnt_q,        cnt_d;
  logic [2:0]            funct3_q,     funct3_d;
  logic [1:0]            lane_q,       lane_d;
  logic                  mem_we_q,     mem_we_d;
  logic                  mem_re_q,     mem_re_d;
  logic [2:0]            mem_funct3_q, mem_funct3_d;
  logic [DATA_WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q,   resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic                  req_err;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;

  // Legality of the incoming request. Illegal funct3 values are reported the
  // same way as misalignment.
  always_comb begin
    req_err = 1'b0;
    if (req_we_i) begin
      case (req_funct3_i)
        FUNCT3_SB: req_err = 1'b0;
        FUNCT3_SH: req_err = req_addr_i[0];
        FUNCT3_SW: req_err = (req_addr_i[1:0] != 2'b00);
        default:   req_err = 1'b1;
      endcase
    end else begin
      case (req_funct3_i)
        FUNCT3_LB, FUNCT3_LBU: req_err = 1'b0;
        FUNCT3_LH, FUNCT3_LHU: req_err = req_addr_i[0];
        FUNCT3_LW:             req_err = (req_addr_i[1:0] != 2'b00);
        default:               req_err = 1'b1;
      endcase
    end
  end

  // Memory always returns the full aligned word. Select the addressed lane.
  always_comb begin
    ld_byte = mem_rdata_i[{lane_q, 3'b000} +: 8];
    ld_half = mem_rdata_i[{lane_q[1], 4'b0000} +: 16];
    case (funct3_q)
      FUNCT3_LB:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      FUNCT3_LBU: ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      FUNCT3_LH:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      FUNCT3_LHU: ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default:    ld_data = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    mem_we_d     = mem_we_q;
    mem_re_d     = mem_re_q;
    mem_funct3_d = mem_funct3_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          funct3_d = req_funct3_i;
          lane_d   = req_addr_i[1:0];
          if (req_err) begin
            // No memory strobe at all; report straight away.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = RESP;
          end else if (req_we_i) begin
            mem_we_d     = 1'b1;
            mem_funct3_d = req_funct3_i;
            mem_addr_d   = req_addr_i;
            mem_wdata_d  = req_wdata_i;
            state_d      = WR;
          end else begin
            // Always read the whole word and extract the lane locally.
            mem_re_d     = 1'b1;
            mem_funct3_d = FUNCT3_LW;
            mem_addr_d   = {req_addr_i[DATA_WIDTH-1:2], 2'b00};
            state_d      = RD;
          end
        end
      end
      WR: begin
        mem_we_d     = 1'b0;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        state_d      = RESP;
      end
      RD: begin
        mem_re_d = 1'b0;
        cnt_d    = WAIT_INIT;
        state_d  = WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = ld_data;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      funct3_q     <= '0;
      lane_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_funct3_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      mem_funct3_q <= mem_funct3_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Ready drops together with reset, so nothing is accepted while it is held.
  assign req_ready_o  = (state_q == IDLE) && !rst;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign MemWrite_en  = mem_we_q;
  assign MemRead_en   = mem_re_q;
  assign MEM_funct3_o = mem_funct3_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit. The driver pushes the expected
// response of each request; the monitor pops and compares on every response
// handshake and checks strobes, latency and hold behaviour.
module tb_mem_access_unit;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [2:0]    req_funct3_i = 3'd0;
  logic [DW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          resp_valid_o;
  logic          resp_ready_i = 1'b0;
  logic [DW-1:0] resp_rdata_o;
  logic          resp_err_o;
  logic          MemWrite_en;
  logic          MemRead_en;
  logic [2:0]    MEM_funct3_o;
  logic [DW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_WIDTH(DW), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .MemWrite_en(MemWrite_en), .MemRead_en(MemRead_en),
    .MEM_funct3_o(MEM_funct3_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // ---------------- data memory model (1 KB, word organised) ----------------
  logic [31:0] dmem [0:255];
  logic [31:0] rd_pipe [0:RD_LAT-1];
  assign mem_rdata_i = rd_pipe[RD_LAT-1];

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd,
                                        logic [2:0] f3, logic [1:0] lane);
    logic [31:0] w;
    int l;
    w = old;
    l = int'(lane);
    case (f3)
      3'd0:    w[8*l +: 8] = wd[7:0];
      3'd1:    w[16*(l/2) +: 16] = wd[15:0];
      default: w = wd;
    endcase
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) dmem[i] <= '0;
    end else if (MemWrite_en) begin
      dmem[mem_addr_o[9:2]] <= merge(dmem[mem_addr_o[9:2]], mem_wdata_o,
                                     MEM_funct3_o, mem_addr_o[1:0]);
    end
    // Data is garbage except RD_LAT edges after a sampled read strobe.
    rd_pipe[0] <= MemRead_en ? dmem[mem_addr_o[9:2]] : $urandom;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  // ---------------- reference model (byte addressed) ----------------
  logic [7:0] ref_mem [0:1023];

  function automatic logic ref_err(logic we, logic [2:0] f3, int a);
    int sz;
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, int a);
    logic [15:0] h;
    h = {ref_mem[a+1], ref_mem[a]};
    case (f3)
      3'd0:    return {{24{ref_mem[a][7]}}, ref_mem[a]};
      3'd4:    return {24'd0, ref_mem[a]};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'd0, h};
      default: return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endcase
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          strobes;
    int          lat;
    logic        we;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- response consumer ----------------
  int ready_mode = 0;  // 0: random acceptance, 1: hold resp_ready_i low
  always @(posedge clk) begin
    #1;
    resp_ready_i = (ready_mode == 0) ? ($urandom_range(0, 2) != 0) : 1'b0;
  end

  // ---------------- monitor ----------------
  logic in_flight = 1'b0;
  logic resp_seen = 1'b0;
  logic expect_idle = 1'b0;
  int   lat_cnt = 0;
  int   strb_cnt = 0;
  int   resp_n = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_flight   = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        chk("idle_after_handshake", 32'(req_ready_o), 32'd1);
        expect_idle = 1'b0;
      end
      if (!in_flight) begin
        chk("quiet_between_txns", {29'd0, resp_valid_o, MemWrite_en, MemRead_en}, 32'd0);
      end else if (exp_q.size() == 0) begin
        chk("scoreboard_nonempty", 32'd0, 32'd1);
        in_flight = 1'b0;
      end else begin
        e = exp_q[0];
        if (MemWrite_en || MemRead_en) begin
          strb_cnt++;
          chk("strobe_addr", mem_addr_o, e.addr);
          chk("strobe_dir", 32'(MemWrite_en), 32'(e.we));
        end
        if (!resp_seen) begin
          lat_cnt++;
          if (resp_valid_o) begin
            resp_seen = 1'b1;
            chk("resp_latency", 32'(lat_cnt), 32'(e.lat));
          end
        end
        if (resp_valid_o) begin
          chk("resp_rdata", resp_rdata_o, e.rdata);
          chk("resp_err", 32'(resp_err_o), 32'(e.err));
          chk("busy_not_ready", 32'(req_ready_o), 32'd0);
          if (resp_ready_i) begin
            chk("strobe_count", 32'(strb_cnt), 32'(e.strobes));
            $display("resp %0d: rdata=0x%08h err=%0b latency=%0d strobes=%0d",
                     resp_n, resp_rdata_o, resp_err_o, lat_cnt, strb_cnt);
            resp_n++;
            void'(exp_q.pop_front());
            in_flight   = 1'b0;
            expect_idle = 1'b1;
          end
        end
      end
      if (req_valid_i && req_ready_o) begin
        in_flight = 1'b1;
        resp_seen = 1'b0;
        lat_cnt   = 0;
        strb_cnt  = 0;
      end
    end
  end

  // ---------------- driver ----------------
  function automatic exp_t build_exp(logic we, logic [2:0] f3, logic [31:0] a,
                                     logic [31:0] wd);
    exp_t e;
    int   n;
    e.we    = we;
    e.rdata = '0;
    e.err   = ref_err(we, f3, int'(a[9:0]));
    if (e.err) begin
      e.strobes = 0;
      e.lat     = 1;
      e.addr    = '0;
    end else if (we) begin
      e.strobes = 1;
      e.lat     = 2;
      e.addr    = a;
      n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      for (int b = 0; b < n; b++) ref_mem[int'(a[9:0]) + b] = wd[8*b +: 8];
    end else begin
      e.strobes = 1;
      e.lat     = RD_LAT + 2;
      e.addr    = {a[31:2], 2'b00};
      e.rdata   = ref_load(f3, int'(a[9:0]));
    end
    return e;
  endfunction

  // Drive one request; called just after a rising edge.
  task automatic send(exp_t e, logic we, logic [2:0] f3, logic [31:0] a,
                      logic [31:0] wd);
    int k;
    exp_q.push_back(e);
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = a;
    req_wdata_i  = wd;
    req_valid_i  = 1'b1;
    k = 0;
    while (!req_ready_o && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!req_ready_o) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      req_valid_i = 1'b0;
      exp_q.delete();
      return;
    end
    @(posedge clk); #1;
    // The unit is busy now; a further valid must be ignored.
    req_valid_i  = ($urandom_range(0, 1) == 1);
    req_we_i     = 1'($urandom_range(0, 1));
    req_funct3_i = 3'($urandom_range(0, 7));
    req_addr_i   = $urandom;
    req_wdata_i  = $urandom;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic issue(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    send(build_exp(we, f3, a, wd), we, f3, a, wd);
  endtask

  task automatic issue_exp(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                           logic [31:0] exp_rdata, logic exp_err);
    exp_t e;
    e = build_exp(we, f3, a, wd);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    send(e, we, f3, a, wd);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int   k;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    int          sz;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready_o), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("reset_strobes", {30'd0, MemWrite_en, MemRead_en}, 32'd0);
    chk("reset_mem_addr", mem_addr_o, 32'd0);
    chk("reset_resp_rdata", resp_rdata_o, 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a load.
    e = build_exp(1'b0, 3'd2, 32'h0, 32'h0);
    exp_q.push_back(e);
    req_we_i = 1'b0; req_funct3_i = 3'd2; req_addr_i = 32'h0; req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("midload_read_strobe", 32'(MemRead_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("midload_rst_read_strobe", 32'(MemRead_en), 32'd0);
    chk("midload_rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("midload_rst_req_ready", 32'(req_ready_o), 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_req_ready", 32'(req_ready_o), 32'd1);

    // Store then load back.
    issue_exp(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    issue_exp(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);

    // Lane extraction.
    issue_exp(1'b1, 3'd2, 32'h300, 32'h80FF7F01, 32'h0, 1'b0);
    issue_exp(1'b0, 3'd0, 32'h300, 32'h0, 32'h00000001, 1'b0);
    issue_exp(1'b0, 3'd0, 32'h302, 32'h0, 32'hFFFFFFFF, 1'b0);
    issue_exp(1'b0, 3'd4, 32'h303, 32'h0, 32'h00000080, 1'b0);
    issue_exp(1'b0, 3'd0, 32'h301, 32'h0, 32'h0000007F, 1'b0);
    issue_exp(1'b0, 3'd1, 32'h302, 32'h0, 32'hFFFF80FF, 1'b0);
    issue_exp(1'b0, 3'd5, 32'h302, 32'h0, 32'h000080FF, 1'b0);

    // Misaligned and illegal requests.
    issue_exp(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 1'b1);
    issue_exp(1'b1, 3'd1, 32'h201, 32'h1234, 32'h0, 1'b1);
    issue_exp(1'b0, 3'd1, 32'h203, 32'h0, 32'h0, 1'b1);
    issue_exp(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1'b1);
    issue_exp(1'b1, 3'd5, 32'h100, 32'h0, 32'h0, 1'b1);
    drain();

    // Backpressure: hold the response, try to push a new request meanwhile.
    ready_mode = 1;
    @(posedge clk); #1;
    issue_exp(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
    k = 0;
    while (!resp_valid_o && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    for (int c = 0; c < 5; c++) begin
      req_valid_i  = 1'b1;
      req_we_i     = 1'b1;
      req_funct3_i = 3'd2;
      req_addr_i   = 32'h104;
      req_wdata_i  = $urandom;
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0;
    chk("bp_resp_held", 32'(resp_valid_o), 32'd1);
    chk("bp_rdata_held", resp_rdata_o, 32'hDEADBEEF);
    ready_mode = 0;
    drain();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) != 0) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          k  = $urandom_range(0, 4);
          f3 = (k < 3) ? 3'(k) : 3'(k + 1);
        end
      end
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        a  = a & ~32'(sz - 1);
      end
      issue(we, f3, a, $urandom);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
